ex_pipe_stage: RTL

EX_PIPE_STAGE -- requirements
Module: ex_pipe_stage

---
 rtl/ex_pipe_stage.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/ex_pipe_stage.sv
// ex_pipe_stage: execute stage of the in-order pipeline.
// ALU, branch resolve, redirect/trap and regfile/LSQ dispatch.
module ex_pipe_stage #(
  parameter int                C_XLEN       = 32,
  parameter bit                C_COMPRESSED = 1'b0,
  parameter logic [C_XLEN-1:0] C_TRAP_VEC   = 'h100
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              clk_en_i,
  input  logic              ids_dav_i,
  output logic              ids_ack_o,
  input  logic [1:0]        ids_zone_i,
  input  logic [3:0]        ids_alu_op_i,
  input  logic              ids_link_i,
  input  logic              ids_jump_i,
  input  logic              ids_branch_i,
  input  logic              ids_ins_size_i,
  input  logic              ids_ins_err_i,
  input  logic [C_XLEN-1:0] ids_pc_i,
  input  logic [C_XLEN-1:0] ids_operand_left_i,
  input  logic [C_XLEN-1:0] ids_operand_right_i,
  input  logic [C_XLEN-1:0] ids_regs1_data_i,
  input  logic [C_XLEN-1:0] ids_regs2_data_i,
  input  logic [4:0]        ids_regd_addr_i,
  input  logic [2:0]        ids_funct3_i,
  output logic              ids_regd_wr_o,
  output logic [4:0]        ids_regd_addr_o,
  output logic [C_XLEN-1:0] ids_regd_data_o,
  input  logic              lsq_full_i,
  output logic              lsq_lq_wr_o,
  output logic              lsq_sq_wr_o,
  output logic [2:0]        lsq_funct3_o,
  output logic [C_XLEN-1:0] lsq_addr_o,
  output logic [C_XLEN-1:0] lsq_regs2_data_o,
  output logic              hvec_strobe_o,
  output logic [C_XLEN-1:0] hvec_vec_o,
  output logic [C_XLEN-1:0] hvec_pc_o,
  output logic              hvec_trap_o
);

  localparam int SW = $clog2(C_XLEN);

  localparam logic [C_XLEN-1:0] ONE  = C_XLEN'(1);
  localparam logic [C_XLEN-1:0] INC4 = C_XLEN'(4);
  localparam logic [C_XLEN-1:0] INC2 = C_XLEN'(2);

  logic              stall;
  logic              accept;
  logic [SW-1:0]     shamt;
  logic [C_XLEN-1:0] sum;
  logic [C_XLEN-1:0] alu;
  logic [C_XLEN-1:0] target;
  logic [C_XLEN-1:0] link_pc;
  logic              lt_s;
  logic              lt_u;
  logic              taken;
  logic              redir;
  logic              trap;

  assign stall  = ids_dav_i & ids_zone_i[1] & lsq_full_i;
  assign ids_ack_o = clk_en_i & ids_dav_i & ~stall;

  // The instruction right behind a redirect is acked but dropped.
  assign accept = ids_ack_o & ~hvec_strobe_o;

  assign shamt  = ids_operand_right_i[SW-1:0];
  assign sum    = ids_operand_left_i + ids_operand_right_i;
  assign target = sum & ~ONE;
  assign link_pc = ids_pc_i + (ids_ins_size_i ? INC4 : INC2);

  assign lt_s = $signed(ids_regs1_data_i) < $signed(ids_regs2_data_i);
  assign lt_u = ids_regs1_data_i < ids_regs2_data_i;

  // ALU result, modulo 2^C_XLEN.
  always_comb begin
    alu = sum;
    case (ids_alu_op_i)
      4'd0: alu = sum;
      4'd1: alu = ids_operand_left_i - ids_operand_right_i;
      4'd2: alu = ids_operand_left_i & ids_operand_right_i;
      4'd3: alu = ids_operand_left_i | ids_operand_right_i;
      4'd4: alu = ids_operand_left_i ^ ids_operand_right_i;
      4'd5: alu = {{(C_XLEN-1){1'b0}},
                   $signed(ids_operand_left_i) <
                   $signed(ids_operand_right_i)};
      4'd6: alu = {{(C_XLEN-1){1'b0}},
                   ids_operand_left_i < ids_operand_right_i};
      4'd7: alu = ids_operand_left_i << shamt;
      4'd8: alu = ids_operand_left_i >> shamt;
      4'd9: alu = $unsigned($signed(ids_operand_left_i) >>> shamt);
      default: alu = sum;
    endcase
  end

  // Branch condition on the compare operands.
  always_comb begin
    taken = 1'b0;
    case (ids_funct3_i)
      3'd0: taken = ids_regs1_data_i == ids_regs2_data_i;
      3'd1: taken = ids_regs1_data_i != ids_regs2_data_i;
      3'd4: taken = lt_s;
      3'd5: taken = ~lt_s;
      3'd6: taken = lt_u;
      3'd7: taken = ~lt_u;
      default: taken = 1'b0;
    endcase
  end

  assign redir = ids_jump_i | (ids_branch_i & taken);
  assign trap  = ids_ins_err_i |
                 (redir & target[1] & ~C_COMPRESSED);

  // Output register: strobes pulse once, data held between accepts.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ids_regd_wr_o    <= 1'b0;
      ids_regd_addr_o  <= '0;
      ids_regd_data_o  <= '0;
      lsq_lq_wr_o      <= 1'b0;
      lsq_sq_wr_o      <= 1'b0;
      lsq_funct3_o     <= '0;
      lsq_addr_o       <= '0;
      lsq_regs2_data_o <= '0;
      hvec_strobe_o    <= 1'b0;
      hvec_vec_o       <= '0;
      hvec_pc_o        <= '0;
      hvec_trap_o      <= 1'b0;
    end else if (clk_en_i) begin
      ids_regd_wr_o <= 1'b0;
      lsq_lq_wr_o   <= 1'b0;
      lsq_sq_wr_o   <= 1'b0;
      hvec_strobe_o <= 1'b0;
      hvec_trap_o   <= 1'b0;
      if (accept) begin
        ids_regd_wr_o    <= ~trap & (ids_zone_i == 2'd1) &
                            (ids_regd_addr_i != 5'd0);
        ids_regd_addr_o  <= ids_regd_addr_i;
        ids_regd_data_o  <= ids_link_i ? link_pc : alu;
        lsq_lq_wr_o      <= ~trap & (ids_zone_i == 2'd2);
        lsq_sq_wr_o      <= ~trap & (ids_zone_i == 2'd3);
        lsq_funct3_o     <= ids_funct3_i;
        lsq_addr_o       <= alu;
        lsq_regs2_data_o <= ids_regs2_data_i;
        hvec_strobe_o    <= trap | redir;
        hvec_trap_o      <= trap;
        hvec_vec_o       <= trap ? C_TRAP_VEC : target;
        hvec_pc_o        <= ids_pc_i;
      end
    end
  end

endmodule
